// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM port, redirect/halt controls and the decode handshake.
interface instr_fetch_unit_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        halted;

  // Fetch unit side
  modport master (
    output rom_addr, if_valid, if_instr, if_pc, halted,
    input  rom_data, redirect_valid, redirect_pc, halt_req, id_ready
  );

  // ROM / execute / decode side
  modport slave (
    input  rom_addr, if_valid, if_instr, if_pc, halted,
    output rom_data, redirect_valid, redirect_pc, halt_req, id_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM and buffers
// {pc, instr} pairs in a small circular FIFO towards decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     last_pc_q, last_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            halted_q, halted_d;
  logic [31:0]     buf_pc_q    [FIFO_DEPTH];
  logic [31:0]     buf_instr_q [FIFO_DEPTH];
  logic            flush, pop, push;

  // Next-state: redirect flushes everything and overrides any push/pop on that edge.
  always_comb begin
    flush     = bus.redirect_valid;
    pop       = (count_q != '0) && bus.id_ready && !flush;
    push      = (state_q == StFetch) && !bus.halt_req && !flush &&
                ((count_q < DepthCnt) || pop);
    state_d   = state_q;
    pc_d      = pc_q;
    last_pc_d = last_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;

    unique case (state_q)
      StBoot:  state_d = bus.halt_req ? StHalt : StFetch;
      StFetch: if (bus.halt_req) state_d = StHalt;
      StHalt:  if (!bus.halt_req) state_d = StFetch;
      default: state_d = StBoot;
    endcase

    if (flush) begin
      // Masking rather than slicing keeps the target word-aligned.
      pc_d     = bus.redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PtrW'(1);
        last_pc_d = buf_pc_q[rd_ptr_q];
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PtrW + 1)'(1);
        2'b01:   count_d = count_q - (PtrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end

    halted_d = (state_d == StHalt) && (count_d == '0);
  end

  // Control state, pointers and the registered halted flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      last_pc_q <= 32'h0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      last_pc_q <= last_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      halted_q  <= halted_d;
    end
  end

  // Buffer storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_pc_q[wr_ptr_q]    <= pc_q;
      buf_instr_q[wr_ptr_q] <= bus.rom_data;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.if_valid = (count_q != '0);
  assign bus.if_instr = (count_q != '0) ? buf_instr_q[rd_ptr_q] : NOP_INSTR;
  assign bus.if_pc    = (count_q != '0) ? buf_pc_q[rd_ptr_q] : last_pc_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the fetch stage.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [64];
  assign bus.rom_data = rom[bus.rom_addr[7:2]];

  // Behavioural model: a queue of {pc, instr} plus the fetch PC and mode flags.
  logic [63:0] m_q[$];
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_last = 32'h0;
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;

  task automatic tick();
    logic [31:0] data;
    bit          pop;
    data = rom[m_pc[7:2]];
    if (rst) begin
      m_pc = 32'h0; m_q.delete(); m_boot = 1'b1; m_halt = 1'b0; m_last = 32'h0;
    end else if (bus.redirect_valid) begin
      m_q.delete();
      m_pc   = {bus.redirect_pc[31:2], 2'b00};
      m_boot = 1'b0;
      m_halt = bus.halt_req;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_halt = bus.halt_req;
    end else begin
      pop = (m_q.size() > 0) && bus.id_ready;
      if (pop) begin
        m_last = m_q[0][63:32];
        void'(m_q.pop_front());
      end
      if (!m_halt && !bus.halt_req && m_q.size() < DEPTH) begin
        m_q.push_back({m_pc, data});
        m_pc = m_pc + 32'd4;
      end
      m_halt = bus.halt_req;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.halt_req = 1'b0; bus.id_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    bus.halt_req = 1'b1; bus.id_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus.if_valid, bus.if_pc, bus.if_instr, bus.halted, bus.rom_addr} !==
        {1'b0, 32'h0, NOP, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b pc=%h instr=%h halted=%b addr=%h, want 0/0/%h/0/0",
               bus.if_valid, bus.if_pc, bus.if_instr, bus.halted, bus.rom_addr, NOP);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [3];
    exp_instr[0] = 32'h0050_0113; exp_instr[1] = 32'h0FBD_01B7; exp_instr[2] = 32'h0631_8193;
    do_reset();
    bus.id_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.if_valid !== 1'b0) begin
      n_fail++; $display("FAIL seq_first_edge: got v=%b want 0", bus.if_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'(4 * i), exp_instr[i]}) begin
        n_fail++;
        $display("FAIL seq_entry%0d: got v=%b pc=%h instr=%h want 1/%h/%h", i,
                 bus.if_valid, bus.if_pc, bus.if_instr, 32'(4 * i), exp_instr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (5) tick();
    n_tests++;
    if ({bus.if_valid, bus.if_pc, bus.rom_addr} !== {1'b1, 32'h0, 32'h8}) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b pc=%h addr=%h want 1/0/8",
               bus.if_valid, bus.if_pc, bus.rom_addr);
    end
    bus.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'(4 * i), rom[i]}) begin
        n_fail++;
        $display("FAIL bp_resume%0d: got v=%b pc=%h instr=%h want 1/%h/%h", i,
                 bus.if_valid, bus.if_pc, bus.if_instr, 32'(4 * i), rom[i]);
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    logic [31:0] tgt [2];
    tgt[0] = 32'h34; tgt[1] = 32'h36;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      repeat (4) tick();
      bus.redirect_valid = 1'b1; bus.redirect_pc = tgt[t];
      tick();
      bus.redirect_valid = 1'b0;
      n_tests++;
      if ({bus.if_valid, bus.rom_addr} !== {1'b0, 32'h34}) begin
        n_fail++;
        $display("FAIL redir_full_bubble%0d: got v=%b addr=%h want 0/34", t,
                 bus.if_valid, bus.rom_addr);
      end
      tick();
      n_tests++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h34, 32'h0001_0183}) begin
        n_fail++;
        $display("FAIL redir_full_target%0d: got v=%b pc=%h instr=%h want 1/34/00010183", t,
                 bus.if_valid, bus.if_pc, bus.if_instr);
      end
      bus.id_ready = 1'b1;
      for (int k = 1; k < 3; k++) begin
        tick();
        n_tests++;
        if ({bus.if_valid, bus.if_pc} !== {1'b1, 32'h34 + 32'(4 * k)}) begin
          n_fail++;
          $display("FAIL redir_full_follow%0d_%0d: got v=%b pc=%h want 1/%h", t, k,
                   bus.if_valid, bus.if_pc, 32'h34 + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    bus.id_ready = 1'b1;
    repeat (4) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h58;
    tick();
    bus.redirect_valid = 1'b0;
    n_tests++;
    if (bus.if_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_pop_bubble: got v=%b want 0", bus.if_valid);
    end
    tick();
    n_tests++;
    if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h58, 32'h0001_0183}) begin
      n_fail++;
      $display("FAIL redir_pop_target: got v=%b pc=%h instr=%h want 1/58/00010183",
               bus.if_valid, bus.if_pc, bus.if_instr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (3) tick();
    bus.halt_req = 1'b1;
    tick();
    n_tests++;
    if ({bus.if_valid, bus.rom_addr, bus.halted} !== {1'b1, 32'h8, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_stop: got v=%b addr=%h halted=%b want 1/8/0",
               bus.if_valid, bus.rom_addr, bus.halted);
    end
    bus.id_ready = 1'b1;
    tick();
    n_tests++;
    if ({bus.if_valid, bus.if_pc, bus.halted} !== {1'b1, 32'h4, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_drain1: got v=%b pc=%h halted=%b want 1/4/0",
               bus.if_valid, bus.if_pc, bus.halted);
    end
    tick();
    n_tests++;
    if ({bus.if_valid, bus.if_pc, bus.halted, bus.rom_addr} !== {1'b0, 32'h4, 1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL halt_drained: got v=%b pc=%h halted=%b addr=%h want 0/4/1/8",
               bus.if_valid, bus.if_pc, bus.halted, bus.rom_addr);
    end
    bus.halt_req = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({bus.if_valid, bus.if_pc, bus.if_instr, bus.halted} !== {1'b1, 32'h8, rom[2], 1'b0}) begin
      n_fail++;
      $display("FAIL halt_resume: got v=%b pc=%h instr=%h halted=%b want 1/8/%h/0",
               bus.if_valid, bus.if_pc, bus.if_instr, bus.halted, rom[2]);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    n_tests++;
    if ({bus.if_valid, bus.if_pc, bus.rom_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap: got v=%b pc=%h addr=%h want 1/fffffffc/0",
               bus.if_valid, bus.if_pc, bus.rom_addr);
    end
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({bus.if_valid, bus.if_pc, bus.if_instr, bus.rom_addr} !== {1'b0, 32'h0, NOP, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b pc=%h instr=%h addr=%h want 0/0/%h/0",
               bus.if_valid, bus.if_pc, bus.if_instr, bus.rom_addr, NOP);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] e_pc, e_instr;
    bit          e_valid, e_halted;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst                = ($urandom_range(0, 99) == 0);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      bus.redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) bus.halt_req = ~bus.halt_req;
      bus.id_ready       = ($urandom_range(0, 2) != 0);
      tick();
      e_valid  = (m_q.size() > 0);
      e_pc     = e_valid ? m_q[0][63:32] : m_last;
      e_instr  = e_valid ? m_q[0][31:0] : NOP;
      e_halted = m_halt && !m_boot && !e_valid;
      n_tests++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr, bus.halted, bus.rom_addr} !==
          {e_valid, e_pc, e_instr, e_halted, m_pc}) begin
        n_fail++;
        $display("FAIL random_c%0d: got v=%b pc=%h instr=%h halted=%b addr=%h want %b/%h/%h/%b/%h",
                 c, bus.if_valid, bus.if_pc, bus.if_instr, bus.halted, bus.rom_addr,
                 e_valid, e_pc, e_instr, e_halted, m_pc);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0]  = 32'h0050_0113;
    rom[1]  = 32'h0FBD_01B7;
    rom[2]  = 32'h0631_8193;
    rom[13] = 32'h0001_0183;
    rom[22] = 32'h0001_0183;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_halt();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
